// File: rtl/rv_pkg.sv
// Shared RISC-V core types: M-extension divide op encoding and divider FSM states.
package rv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Encoding matches funct3[1:0] of DIV/DIVU/REM/REMU.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/rv_div_unit.sv
// Iterative 32-bit divider for DIV/DIVU/REM/REMU: restoring division on magnitudes,
// one quotient bit per cycle, with divide-by-zero and signed overflow answered immediately.
module rv_div_unit
    import rv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_rs1_value,
    input  logic [XLEN-1:0] in_rs2_value,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_value
);

    div_state_t       state_q;
    div_op_t          op_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             out_valid_q;
    logic [4:0]       out_rd_q;
    logic [XLEN-1:0]  out_value_q;

    div_op_t          in_op_e;
    logic             accept;
    logic             in_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div_zero;
    logic             sgn_ovf;
    logic [XLEN-1:0]  special_value;

    logic [XLEN:0]    rem_shift;
    logic             rem_ge;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  busy_value;

    assign in_ready  = (state_q == ST_IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_rd    = out_rd_q;
    assign out_value = out_value_q;

    // Request decode: operand magnitudes, sign flags and the two early-out cases.
    assign in_op_e  = div_op_t'(in_op);
    assign in_sgn   = op_is_signed(in_op_e);
    assign a_neg    = in_sgn && in_rs1_value[XLEN-1];
    assign b_neg    = in_sgn && in_rs2_value[XLEN-1];
    assign a_mag    = a_neg ? -in_rs1_value : in_rs1_value;
    assign b_mag    = b_neg ? -in_rs2_value : in_rs2_value;
    assign div_zero = (in_rs2_value == '0);
    assign sgn_ovf  = in_sgn && (in_rs1_value == INT_MIN) && (in_rs2_value == '1);

    always_comb begin
        special_value = '0;
        if (div_zero) begin
            special_value = op_is_rem(in_op_e) ? in_rs1_value : '1;
        end else begin
            special_value = op_is_rem(in_op_e) ? '0 : INT_MIN;
        end
    end

    // One restoring step: the dividend shifts out of quo_q as quotient bits shift in.
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    assign rem_d     = rem_ge ? XLEN'(rem_shift - {1'b0, dvs_q}) : rem_shift[XLEN-1:0];
    assign quo_d     = {quo_q[XLEN-2:0], rem_ge};

    assign quo_fix    = (op_is_signed(op_q) && neg_quo_q) ? -quo_d : quo_d;
    assign rem_fix    = (op_is_signed(op_q) && neg_rem_q) ? -rem_d : rem_d;
    assign busy_value = op_is_rem(op_q) ? rem_fix : quo_fix;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_DIV;
            rd_q        <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_value_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= in_op_e;
                        rd_q      <= in_rd;
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (div_zero || sgn_ovf) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_rd_q    <= in_rd;
                            out_value_q <= special_value;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        out_rd_q    <= rd_q;
                        out_value_q <= busy_value;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_rd_q    <= '0;
                        out_value_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_div_unit.sv
// Scoreboard bench for rv_div_unit: expected results are queued at request time and
// compared when the divider presents its result.
module tb_rv_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b00;
    logic [31:0] in_rs1_value = '0;
    logic [31:0] in_rs2_value = '0;
    logic [4:0]  in_rd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_value;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    rv_div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1_value(in_rs1_value),
        .in_rs2_value(in_rs2_value),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_value   (out_value)
    );

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb_v;
        sa   = a;
        sb_v = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb_v);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb_v);
            default: return a % b;
        endcase
    endfunction

    // Present a request, push its expected result, return #1 after the accept edge.
    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        exp_t e;
        int   k;
        @(negedge clock);
        in_op = op; in_rs1_value = a; in_rs2_value = b; in_rd = rd; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        e.rd    = rd;
        e.value = model(op, a, b);
        e.lat   = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
        sb.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_op = 2'($urandom); in_rs1_value = $urandom; in_rs2_value = $urandom;
        in_rd = 5'($urandom);
    endtask

    // Posedges from the accept edge (counted as 1) until out_valid is seen; bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic release_out;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({out_valid, out_rd, out_value} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b rd=%0d val=%h want all zero",
                     out_valid, out_rd, out_value);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_high: got %b want 0", in_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b want 1", in_ready);
        end
    endtask

    task automatic test_div_basic;
        logic [1:0] ops[2] = '{2'b00, 2'b10};
        exp_t e;
        int   lat;
        foreach (ops[i]) begin
            drive_req(ops[i], 32'd100, 32'd7, 5'd5);
            wait_out(lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value}) begin
                n_fail++;
                $display("FAIL basic_result op=%0d: got v=%b rd=%0d val=%h want v=1 rd=%0d val=%h",
                         ops[i], out_valid, out_rd, out_value, e.rd, e.value);
            end
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL basic_latency op=%0d: got %0d want %0d", ops[i], lat, e.lat);
            end
            release_out();
            n_checks++;
            if ({out_valid, out_rd, out_value, in_ready} !== {38'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL basic_idle: got v=%b rd=%0d val=%h rdy=%b want 0/0/0/1",
                         out_valid, out_rd, out_value, in_ready);
            end
        end
    endtask

    task automatic test_signed;
        logic [1:0] ops[3] = '{2'b00, 2'b10, 2'b01};
        exp_t e;
        int   lat;
        foreach (ops[i]) begin
            drive_req(ops[i], 32'hFFFF_FFF9, 32'd2, 5'd17);
            wait_out(lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value}) begin
                n_fail++;
                $display("FAIL signed_result op=%0d: got v=%b rd=%0d val=%h want v=1 rd=%0d val=%h",
                         ops[i], out_valid, out_rd, out_value, e.rd, e.value);
            end
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL signed_latency op=%0d: got %0d want %0d", ops[i], lat, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_div_zero;
        logic [1:0] ops[4] = '{2'b01, 2'b11, 2'b00, 2'b10};
        exp_t e;
        int   lat;
        foreach (ops[i]) begin
            drive_req(ops[i], 32'd5, 32'd0, 5'd0);
            wait_out(lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value}) begin
                n_fail++;
                $display("FAIL divzero_result op=%0d: got v=%b rd=%0d val=%h want v=1 rd=%0d val=%h",
                         ops[i], out_valid, out_rd, out_value, e.rd, e.value);
            end
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL divzero_latency op=%0d: got %0d want %0d", ops[i], lat, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_overflow;
        logic [1:0] ops[2] = '{2'b00, 2'b10};
        exp_t e;
        int   lat;
        foreach (ops[i]) begin
            drive_req(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd31);
            wait_out(lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value}) begin
                n_fail++;
                $display("FAIL overflow_result op=%0d: got v=%b rd=%0d val=%h want v=1 rd=%0d val=%h",
                         ops[i], out_valid, out_rd, out_value, e.rd, e.value);
            end
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++;
                $display("FAIL overflow_latency op=%0d: got %0d want %0d", ops[i], lat, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   lat;
        drive_req(2'b01, 32'd1000, 32'd3, 5'd9);
        wait_out(lat);
        e = sb.pop_front();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            n_checks++;
            if ({out_valid, in_ready, out_rd, out_value} !== {2'b10, e.rd, e.value}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b rd=%0d val=%h want v=1 rdy=0 rd=%0d val=%h",
                         c, out_valid, in_ready, out_rd, out_value, e.rd, e.value);
            end
        end
        release_out();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_busy;
        exp_t e;
        int   lat;
        logic saw;
        drive_req(2'b00, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_back());
        saw = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (out_valid) saw = 1'b1;
        end
        n_checks++;
        if ({saw, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_busy: got saw_valid=%b rdy=%b want 0/1", saw, in_ready);
        end
        drive_req(2'b00, 32'd100, 32'd7, 5'd5);
        wait_out(lat);
        e = sb.pop_front();
        n_checks++;
        if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value} || lat !== e.lat) begin
            n_fail++;
            $display("FAIL after_abort: got v=%b rd=%0d val=%h lat=%0d want v=1 rd=%0d val=%h lat=%0d",
                     out_valid, out_rd, out_value, lat, e.rd, e.value, e.lat);
        end
        // Reset wins over a simultaneous consumer handshake.
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({out_valid, out_rd, out_value} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_in_done: got v=%b rd=%0d val=%h want zero",
                     out_valid, out_rd, out_value);
        end
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_done_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back;
        exp_t        e;
        int          lat;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (i == 3) begin
                op = 2'b10; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            drive_req(op, a, b, 5'(i + 1));
            wait_out(lat);
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, out_rd, out_value} !== {1'b1, e.rd, e.value} || lat !== e.lat) begin
                n_fail++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h: got v=%b rd=%0d val=%h lat=%0d want rd=%0d val=%h lat=%0d",
                         i, op, a, b, out_valid, out_rd, out_value, lat, e.rd, e.value, e.lat);
            end
        end
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv_div_unit.md
RV_DIV_UNIT -- requirements
Module: rv_div_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clock  input  1  clock; all state updates on posedge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 in_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-007 in_rs1_value  input  32  dividend, from register file rs1 read port.
REQ-008 in_rs2_value  input  32  divisor, from register file rs2 read port.
REQ-009 in_rd  input  5  destination register index.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_rd  output  5  destination index, feeds register file rd.
REQ-013 out_value  output  32  result, feeds register file rd_store_value.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE) && !reset.
REQ-015 Accept = in_valid && in_ready; on accept, latch op, rd, operand magnitudes, sign flags.
REQ-016 IDLE -> BUSY on accept with divisor nonzero and not (signed op, dividend 0x80000000, divisor 0xFFFFFFFF).
REQ-017 IDLE -> DONE on accept of divide-by-zero or signed overflow; out_valid asserted in the cycle after the accept edge.
REQ-018 BUSY: unsigned restoring division, one quotient bit per cycle, 33-bit partial remainder, 5-bit counter; exactly 32 BUSY cycles, then DONE.
REQ-019 Normal latency: out_valid first high 33 cycles after the accept edge.
REQ-020 Signed ops: divide magnitudes; negate quotient iff operand signs differ; remainder takes dividend sign.
REQ-021 Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = dividend unchanged.
REQ-022 Signed overflow (0x80000000 / -1): DIV result 0x80000000, REM result 0.
REQ-023 DONE: out_valid=1; out_rd, out_value held stable until out_valid && out_ready.
REQ-024 DONE -> IDLE on out_valid && out_ready; no request accepted in that same cycle.
REQ-025 in_* ignored outside IDLE; in_* values may change freely after accept.
REQ-026 in_rd = 0 processed normally; out_rd = 0 emitted, register file discards it.
REQ-027 out_value = 0 and out_rd = 0 whenever out_valid = 0.

Reset
REQ-028 reset in any state -> IDLE next edge; in-flight operation abandoned, no result emitted.
REQ-029 After reset: out_valid=0, out_rd=0, out_value=0, counter=0; in_ready=1 from the first cycle with reset low.
REQ-030 reset overrides a simultaneous accept or out_ready handshake.

Structure
REQ-031 Op encoding enum (div_op_t) and state enum belong in shared package rv_pkg.
REQ-032 Single module; no sub-module; sign fix-up and special-case detection are local combinational logic.

Verification
REQ-033 DIV 100 / 7, rd=5 -> out_value 14 (REM: 2), out_rd 5, out_valid 33 cycles after accept.
REQ-034 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU same operands -> 0x7FFFFFFC.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, each out_valid 1 cycle after accept.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
REQ-037 out_ready held low 5 cycles in DONE -> out_valid, out_value stable, in_ready 0; release -> IDLE next cycle.
REQ-038 reset at 10th BUSY cycle -> IDLE, out_valid never asserts; next request 100/7 -> 14 correctly.
